// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver with an AXI-Stream source port.
//
// Samples the asynchronous serial line mid-bit, assembles LSB-first bytes and
// presents each one as a single AXI-Stream beat from a one-entry holding
// register. Framing and overrun errors are reported as one-cycle pulses.
//
// Ports:
//   clk            system clock
//   reset          asynchronous, active-high reset
//   rxd            serial input, idle high, asynchronous to clk
//   m_axis_tdata   received byte, bit 0 = first data bit on the wire
//   m_axis_tvalid  holding register contains an undelivered byte
//   m_axis_tready  downstream accepts the beat
//   framing_error  one-cycle pulse: stop bit sampled low
//   overrun_error  one-cycle pulse: completed byte dropped, holding register full
//   rx_busy        receiver is anywhere but idle
module uart_rx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxd,
  output logic [DATA_BITS-1:0] m_axis_tdata,
  output logic                 m_axis_tvalid,
  input  logic                 m_axis_tready,
  output logic                 framing_error,
  output logic                 overrun_error,
  output logic                 rx_busy
);

  localparam int unsigned HALF = CLKS_PER_BIT / 2;
  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned IdxW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CntW-1:0] HalfLast = CntW'(HALF - 1);
  localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] IdxLast  = IdxW'(DATA_BITS - 1);

  localparam logic [2:0] StIdle      = 3'd0;
  localparam logic [2:0] StStart     = 3'd1;
  localparam logic [2:0] StData      = 3'd2;
  localparam logic [2:0] StStop      = 3'd3;
  localparam logic [2:0] StBreakWait = 3'd4;

  logic                 rx_meta_q, rx_s_q;
  logic [2:0]           state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IdxW-1:0]      bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] tdata_q, tdata_d;
  logic                 tvalid_q, tvalid_d;
  logic                 ferr_q, ferr_d;
  logic                 oerr_q, oerr_d;
  logic                 deliver;

  // Two-flop synchronizer; both stages reset to the idle (high) line level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rxd;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 1'b1;
    bit_idx_d = bit_idx_q;
    shift_d   = shift_q;
    tdata_d   = tdata_q;
    tvalid_d  = tvalid_q;
    ferr_d    = 1'b0;
    oerr_d    = 1'b0;
    deliver   = 1'b0;

    if (tvalid_q && m_axis_tready) tvalid_d = 1'b0;

    case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (!rx_s_q) state_d = StStart;
      end
      StStart: begin
        // Re-check the start bit at its middle; a high line here was a glitch.
        if (cnt_q == HalfLast) begin
          cnt_d     = '0;
          bit_idx_d = '0;
          state_d   = rx_s_q ? StIdle : StData;
        end
      end
      StData: begin
        if (cnt_q == BitLast) begin
          cnt_d              = '0;
          shift_d[bit_idx_q] = rx_s_q;
          if (bit_idx_q == IdxLast) state_d = StStop;
          else                      bit_idx_d = bit_idx_q + 1'b1;
        end
      end
      StStop: begin
        if (cnt_q == BitLast) begin
          cnt_d = '0;
          if (rx_s_q) begin
            deliver = 1'b1;
            state_d = StIdle;
          end else begin
            ferr_d  = 1'b1;
            state_d = StBreakWait;
          end
        end
      end
      StBreakWait: begin
        // Hold off until the line returns high so a break cannot retrigger START.
        cnt_d = '0;
        if (rx_s_q) state_d = StIdle;
      end
      default: begin
        cnt_d   = '0;
        state_d = StIdle;
      end
    endcase

    // A full register that is draining this cycle can take the new byte.
    if (deliver) begin
      if (!tvalid_q || m_axis_tready) begin
        tdata_d  = shift_q;
        tvalid_d = 1'b1;
      end else begin
        oerr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= StIdle;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      tdata_q   <= '0;
      tvalid_q  <= 1'b0;
      ferr_q    <= 1'b0;
      oerr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_idx_q <= bit_idx_d;
      shift_q   <= shift_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      ferr_q    <= ferr_d;
      oerr_q    <= oerr_d;
    end
  end

  assign m_axis_tdata  = tdata_q;
  assign m_axis_tvalid = tvalid_q;
  assign framing_error = ferr_q;
  assign overrun_error = oerr_q;
  assign rx_busy       = (state_q != StIdle);

endmodule
